// File: rtl/aes_key_pkg.sv
// Shared sizing constants, types and GF(2^8) helpers for the AES-128 key schedule.
// The S-box table here is also the one used by the core's sub_bytes.
package aes_key_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_KEYS   = 11;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_state_t;

    typedef logic [127:0] round_key_t;

    // Byte 0x00 sits in the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SBOX_TABLE[idx * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expansion_sub_word.sv
// SubWord for the key schedule: four parallel S-box lookups on a 32-bit word.
module key_sub_word
    import aes_key_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Byte-wise substitution, no state.
    always_comb begin
        word_out = {sbox_lookup(word_in[31:24]), sbox_lookup(word_in[23:16]),
                    sbox_lookup(word_in[15:8]),  sbox_lookup(word_in[7:0])};
    end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key expansion: builds the 11-entry round-key file one key per cycle
// and serves it through a combinational address mux plus a dedicated round-0 port.
module aes_key_expansion
    import aes_key_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic [3:0]   round_key_addr,
    output logic [127:0] round_key_output,
    output logic [127:0] round_key_0,
    output logic         keys_ready,
    output logic         busy
);

    key_state_t state_r;
    key_state_t next_state_s;
    logic [3:0] cnt_r;
    logic [7:0] rcon_r;
    round_key_t key_file_r [0:NUM_KEYS-1];
    logic       keys_ready_r;
    logic       busy_r;

    logic       load_s;
    logic       expand_s;
    round_key_t prev_key_s;
    round_key_t next_key_s;
    logic [31:0] rot_word_s;
    logic [31:0] sub_word_s;
    logic [31:0] temp_s;
    logic [31:0] w0_s, w1_s, w2_s, w3_s;

    // Next-state and action decode.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        expand_s     = 1'b0;
        case (state_r)
            IDLE, READY: begin
                if (key_load) begin
                    load_s       = 1'b1;
                    next_state_s = EXPAND;
                end else begin
                    next_state_s = state_r;
                end
            end
            EXPAND: begin
                expand_s = 1'b1;
                if (cnt_r == 4'(NUM_ROUNDS)) begin
                    next_state_s = READY;
                end else begin
                    next_state_s = EXPAND;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // One schedule step: RotWord/SubWord/rcon on w3, then a 4-deep XOR chain.
    always_comb begin
        prev_key_s = key_file_r[cnt_r - 4'd1];
        rot_word_s = {prev_key_s[23:0], prev_key_s[31:24]};
        temp_s     = sub_word_s ^ {rcon_r, 24'h000000};
        w0_s       = prev_key_s[127:96] ^ temp_s;
        w1_s       = prev_key_s[95:64]  ^ w0_s;
        w2_s       = prev_key_s[63:32]  ^ w1_s;
        w3_s       = prev_key_s[31:0]   ^ w2_s;
        next_key_s = {w0_s, w1_s, w2_s, w3_s};
    end

    key_sub_word u_sub_word (
        .word_in  (rot_word_s),
        .word_out (sub_word_s)
    );

    // State, round counter, rcon and the registered status decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            rcon_r       <= RCON_INIT;
            keys_ready_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            keys_ready_r <= (next_state_s == READY);
            busy_r       <= (next_state_s == EXPAND);
            if (load_s) begin
                cnt_r  <= 4'd1;
                rcon_r <= RCON_INIT;
            end else if (expand_s) begin
                cnt_r  <= cnt_r + 4'd1;
                rcon_r <= xtime(rcon_r);
            end
        end
    end

    // Key file: entry 0 on load, entry[cnt] during expansion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_file_r[i] <= '0;
            end
        end else if (load_s) begin
            key_file_r[0] <= key_in;
        end else if (expand_s) begin
            key_file_r[cnt_r] <= next_key_s;
        end
    end

    // Round-key lookup; out-of-range addresses read as zero.
    always_comb begin
        if (round_key_addr < 4'(NUM_KEYS)) begin
            round_key_output = key_file_r[round_key_addr];
        end else begin
            round_key_output = '0;
        end
    end

    assign round_key_0 = key_file_r[0];
    assign keys_ready  = keys_ready_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: FIPS-197 vectors, random keys
// against a GF(2^8)-derived reference schedule, and load/reset corner sequences.
module tb_aes_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   round_key_addr;
    logic [127:0] round_key_output;
    logic [127:0] round_key_0;
    logic         keys_ready;
    logic         busy;

    int total_checks = 0;
    int passed_checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_keys [11];

    typedef struct {
        logic [127:0] key;
        logic [3:0]   addr;
        logic [127:0] expected;
    } vec_t;
    vec_t vecs [7];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expansion dut (
        .clk              (clk),
        .rst              (rst),
        .key_load         (key_load),
        .key_in           (key_in),
        .round_key_addr   (round_key_addr),
        .round_key_output (round_key_output),
        .round_key_0      (round_key_0),
        .keys_ready       (keys_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (a^254) then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(a));
            b = inv;
            sbox_m[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // Textbook word-oriented schedule over w[0..43].
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total_checks++;
        if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
        else passed_checks++;
    endtask

    // Pulse key_load for one edge (E1) and count further edges until keys_ready.
    task automatic load_and_wait(input logic [127:0] k, output int edges);
        key_in   = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        edges = 0;
        while (!keys_ready && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            round_key_addr = 4'(a);
            #1;
            if (a < 11) check($sformatf("%s addr %0d", tag, a), round_key_output, exp_keys[a]);
            else        check($sformatf("%s addr %0d", tag, a), round_key_output, 128'd0);
        end
    endtask

    initial begin
        int edges;
        logic [127:0] loaded;
        logic [127:0] key_a, key_b, key_c;

        rst = 1'b1; key_load = 1'b0; key_in = 128'd0; round_key_addr = 4'd0;
        build_sbox();

        vecs[0] = '{FIPS_KEY, 4'd0,  FIPS_KEY};
        vecs[1] = '{FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{FIPS_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{FIPS_KEY, 4'd11, 128'd0};
        vecs[4] = '{128'd0,   4'd1,  128'h62636363626363636263636362636363};
        vecs[5] = '{128'd0,   4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[6] = '{128'd0,   4'd15, 128'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset round_key_0", round_key_0, 128'd0);
        check("reset round_key_output", round_key_output, 128'd0);
        check("reset keys_ready", {127'd0, keys_ready}, 128'd0);
        check("reset busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;

        // Table-driven known-answer vectors.
        loaded = 128'hx;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].key !== loaded) begin
                load_and_wait(vecs[v].key, edges);
                check("ready latency", 128'(edges), 128'd10);
                check("round_key_0 = key_in", round_key_0, vecs[v].key);
                loaded = vecs[v].key;
            end
            round_key_addr = vecs[v].addr;
            #1;
            check($sformatf("vector %0d addr %0d", v, vecs[v].addr), round_key_output, vecs[v].expected);
        end

        // Random keys against the reference schedule, full address sweep.
        for (int r = 0; r < 4; r++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key_a);
            load_and_wait(key_a, edges);
            check("random ready latency", 128'(edges), 128'd10);
            sweep("random");
        end

        // Load arriving at E5 is dropped; original key completes on schedule.
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = ~key_a;
        key_in = key_a; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        check("busy after E1", {127'd0, busy}, 128'd1);
        check("keys_ready low after E1", {127'd0, keys_ready}, 128'd0);
        repeat (3) begin @(posedge clk); #1; end
        key_in = key_b; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        edges = 4;
        while (!keys_ready && edges < 20) begin @(posedge clk); #1; edges++; end
        check("mid-load ready latency", 128'(edges), 128'd10);
        model_expand(key_a);
        check("mid-load round_key_0", round_key_0, key_a);
        round_key_addr = 4'd10; #1;
        check("mid-load entry 10", round_key_output, exp_keys[10]);

        // Reload from READY with key_load held across two edges.
        key_c = {$urandom, $urandom, $urandom, $urandom};
        key_in = key_c; key_load = 1'b1;
        @(posedge clk); #1;
        check("reload keys_ready drop", {127'd0, keys_ready}, 128'd0);
        check("reload busy", {127'd0, busy}, 128'd1);
        @(posedge clk); #1;
        key_load = 1'b0;
        edges = 1;
        while (!keys_ready && edges < 20) begin @(posedge clk); #1; edges++; end
        check("reload ready latency", 128'(edges), 128'd10);
        model_expand(key_c);
        round_key_addr = 4'd10; #1;
        check("reload entry 10", round_key_output, exp_keys[10]);

        // Asynchronous reset in the cycle after E6.
        key_in = key_a; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("async reset round_key_0", round_key_0, 128'd0);
        check("async reset busy", {127'd0, busy}, 128'd0);
        check("async reset keys_ready", {127'd0, keys_ready}, 128'd0);
        round_key_addr = 4'd3; #1;
        check("async reset entry 3", round_key_output, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle after reset busy", {127'd0, busy}, 128'd0);
        check("idle after reset keys_ready", {127'd0, keys_ready}, 128'd0);
        model_expand(FIPS_KEY);
        load_and_wait(FIPS_KEY, edges);
        check("post-reset ready latency", 128'(edges), 128'd10);
        sweep("post-reset");

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
